// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first, idle-high line.
// Each frame is recovered by mid-bit sampling against a per-bit clock count.
// The received byte is presented in a holding register with a valid/read
// handshake, and frame-error and overrun are reported as one-cycle pulses.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line idle, clock counter held at 0, waiting for rx_s low
// START     | qualifying the start bit at its midpoint
// DATA      | sampling DATA_BITS data bits, one per CLKS_PER_BIT clocks
// STOP      | sampling the stop bit; high loads the byte, low is an error
// WAIT_HIGH | after a bad stop bit, wait for the line to return high

module uart_rx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic                 rx,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(DATA_BITS + 1);

   // Start bit is checked half a bit in, so every later sample lands mid-bit.
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] NBITS   = BW'(DATA_BITS);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CW-1:0]        clk_cnt;
   logic [CW-1:0]        clk_cnt_nxt;
   logic [BW-1:0]        bit_cnt;
   logic [BW-1:0]        bit_cnt_nxt;
   logic [BW-1:0]        bit_inc;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] shift_nxt;
   logic [1:0]           sync_q;
   logic                 rx_s;
   logic                 load;
   logic                 stop_bad;

   // Two-flop synchronizer; nothing else looks at the raw rx pin.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx};
      end
   end

   assign rx_s    = sync_q[1];
   assign bit_inc = bit_cnt + 1'b1;

   // State register, counters and shift register.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         state     <= state_nxt;
         clk_cnt   <= clk_cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shift_reg <= shift_nxt;
      end
   end

   // Next-state, counter and strobe logic; counters clear on every state entry.
   always_comb begin
      state_nxt   = state;
      clk_cnt_nxt = clk_cnt;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift_reg;
      load        = 1'b0;
      stop_bad    = 1'b0;
      case (state)
         IDLE: begin
            clk_cnt_nxt = '0;
            bit_cnt_nxt = '0;
            if (!rx_s) begin
               state_nxt = START;
            end
         end
         START: begin
            if (clk_cnt == HALF_M1) begin
               clk_cnt_nxt = '0;
               bit_cnt_nxt = '0;
               // A line that is already high again was a glitch, not a start.
               state_nxt   = rx_s ? IDLE : DATA;
            end else begin
               clk_cnt_nxt = clk_cnt + 1'b1;
            end
         end
         DATA: begin
            if (clk_cnt == FULL_M1) begin
               clk_cnt_nxt = '0;
               shift_nxt   = {rx_s, shift_reg[DATA_BITS-1:1]};
               if (bit_inc == NBITS) begin
                  bit_cnt_nxt = '0;
                  state_nxt   = STOP;
               end else begin
                  bit_cnt_nxt = bit_inc;
               end
            end else begin
               clk_cnt_nxt = clk_cnt + 1'b1;
            end
         end
         STOP: begin
            if (clk_cnt == FULL_M1) begin
               clk_cnt_nxt = '0;
               bit_cnt_nxt = '0;
               if (rx_s) begin
                  load      = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  stop_bad  = 1'b1;
                  state_nxt = WAIT_HIGH;
               end
            end else begin
               clk_cnt_nxt = clk_cnt + 1'b1;
            end
         end
         WAIT_HIGH: begin
            // Holding here through a break keeps it to a single frame_err.
            clk_cnt_nxt = '0;
            bit_cnt_nxt = '0;
            if (rx_s) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt   = IDLE;
            clk_cnt_nxt = '0;
            bit_cnt_nxt = '0;
         end
      endcase
   end

   // Holding register with valid/read handshake and error pulses.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         if (load) begin
            data_out   <= shift_reg;
            data_valid <= 1'b1;
            // A same-cycle read consumes the old byte, so nothing is lost.
            overrun    <= data_valid && !rd_en;
         end else begin
            overrun <= 1'b0;
            if (rd_en) begin
               data_valid <= 1'b0;
            end
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1 format, LSB first, idle-high line.
- Counterpart of the logger's serial transmit path; takes host commands and configuration bytes off the rx pin.
- Recovers each frame by mid-bit sampling against a per-bit clock count.
- Presents each byte in a holding register with a valid/read handshake, plus frame-error and overrun flags.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); must be >= 4
DATA_BITS, 8, data bits per frame (5..9)

Ports:
clk  input  1  system clock, all logic on posedge
clr_n  input  1  asynchronous active-low reset
rx  input  1  serial line, asynchronous to clk, idle high
rd_en  input  1  consumer acknowledges the held byte; clears data_valid
data_out  output  DATA_BITS  held received byte
data_valid  output  1  level; high while an unread byte is held
frame_err  output  1  one-cycle pulse; stop bit sampled low
overrun  output  1  one-cycle pulse; unread byte overwritten
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: clr_n low asynchronously forces the following values:
  - data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0.
  - FSM=IDLE, bit counter=0, clock counter=0.
  - Both synchronizer flops=1.
- Input path: rx passes through a 2-flop synchronizer (rx_s); no other logic touches raw rx.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: clock counter is held at 0. When rx_s=0, go to START.
  - START: count clocks. At count == CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
    - rx_s=0: clear counter, go to DATA.
    - rx_s=1: false start; return to IDLE with no flag.
  - DATA: at count == CLKS_PER_BIT-1, sample rx_s and shift it into the MSB of the shift register (right shift, LSB first).
    - The counter wraps to 0 and the bit counter increments.
    - After DATA_BITS samples, go to STOP.
  - STOP: at count == CLKS_PER_BIT-1, sample rx_s.
    - rx_s=1: go to IDLE and raise the load strobe.
    - rx_s=0: pulse frame_err for one cycle, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. A held-low line (break) therefore produces exactly one frame_err and no retriggering.
- Holding register:
  - On the load strobe, data_out takes the shift register value and data_valid=1 from the next cycle.
  - rd_en while data_valid=1 clears data_valid on the next cycle; rd_en while data_valid=0 is ignored.
  - Load while data_valid=1 and rd_en=0: data_out is overwritten, data_valid stays 1, overrun pulses for one cycle.
  - Load and rd_en in the same cycle: new byte loaded, data_valid stays 1, no overrun.
- Latency: data_valid rises 3 clk cycles after the stop-bit sample point as seen at the rx pin (2 synchronizer cycles + 1 load cycle).
- Back-to-back frames: a start bit that begins immediately after the stop-bit sample is accepted. The receiver tolerates ±4% baud mismatch at CLKS_PER_BIT ≥ 16.
- Counters: clock counter width is clog2(CLKS_PER_BIT); bit counter width is clog2(DATA_BITS+1). Both reset to 0 on every state entry.
- Reset mid-frame returns to IDLE cleanly; the partial byte is lost and no flag is raised.

Test Plan:
- CLKS_PER_BIT=8. Send 0xA5 (LSB first) at exact baud -> data_out=0xA5, data_valid=1, frame_err=0; pulse rd_en -> data_valid=0 next cycle.
- 3-cycle low glitch on idle rx -> START aborts at its mid-bit sample; busy returns to 0; no data_valid, no frame_err.
- Send 0x3C with the stop bit driven low, then hold rx low for 40 cycles -> exactly one frame_err pulse, data_valid stays 0. Release rx and send 0x81 -> data_out=0x81 valid.
- Send 0x11 then 0x22 back-to-back without rd_en -> data_out=0x22, data_valid=1, overrun pulses once. Repeat with rd_en asserted on the load cycle -> no overrun.
- Assert clr_n low during bit 4 of a frame, release, then send 0x5A -> all outputs 0 during reset; after release, 0x5A is received correctly.
- Run all 256 byte values back-to-back at +3% and -3% bit period -> every byte matches and no errors are flagged.
